systolic_result_drain: RTL and testbench

- Drains the accumulated outputs of the systolic array datapath once a matrix multiply has finished.
- Drives the array's row/column output selects, captures the selected partial sum and streams the results out in row-major order over a val/rdy interface.
- Sits between the systolic datapath's output mux (`out_rsel`, `out_csel`, `b_s_out`) and the downstream consumer (SPI/response path), and is started by the array controller.

---
 rtl/systolic_result_drain_if.sv | 14 +
 rtl/systolic_result_drain.sv | 85 ++++++++
 tb/tb_systolic_result_drain.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// Result stream from the drain to its consumer: one word plus its {row,col}
// index, moved on a val/rdy handshake.
interface systolic_result_drain_if #(
    parameter int size  = 16,
    parameter int nbits = 16
);
    logic [nbits-1:0]           send_msg;
    logic [2*$clog2(size)-1:0]  send_idx;
    logic                       send_val;
    logic                       send_rdy;

    modport master (output send_msg, send_idx, send_val, input send_rdy);
    modport slave  (input send_msg, send_idx, send_val, output send_rdy);
endinterface

// File: rtl/systolic_result_drain.sv
// Walks the systolic array output mux row-major, latching each PE sum and
// streaming it out with its {row,col} index; pulses done after the last word.
//
// state | meaning
// IDLE  | waiting for start, selects parked at (0,0)
// FETCH | selects driven from the index, datapath sum captured at the edge
// SEND  | word offered downstream, held until accepted
// DONE  | one-cycle done pulse, index returns to (0,0)
module systolic_result_drain #(
    parameter int size  = 16,
    parameter int nbits = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [$clog2(size)-1:0]  out_rsel,
    output logic [$clog2(size)-1:0]  out_csel,
    input  logic [nbits-1:0]         b_s_out,
    systolic_result_drain_if.master  send,
    output logic                     busy,
    output logic                     done
);
    localparam int lw = $clog2(size);
    localparam logic [lw-1:0] last_pos = lw'(size - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
    state_t state;

    // The select registers double as the drain index, so the mux input is
    // stable for the whole FETCH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            out_rsel      <= '0;
            out_csel      <= '0;
            send.send_msg <= '0;
            send.send_idx <= '0;
            send.send_val <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        out_rsel <= '0;
                        out_csel <= '0;
                    end
                end
                FETCH: begin
                    send.send_msg <= b_s_out;
                    send.send_idx <= {out_rsel, out_csel};
                    send.send_val <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    if (send.send_rdy) begin
                        send.send_val <= 1'b0;
                        if (out_rsel == last_pos && out_csel == last_pos) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            if (out_csel == last_pos) begin
                                out_csel <= '0;
                                out_rsel <= out_rsel + lw'(1);
                            end else begin
                                out_csel <= out_csel + lw'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    out_rsel <= '0;
                    out_csel <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: a size-4 instance for directed timing and
// handshake scenarios, a size-16 instance for a randomised full drain.
module tb_systolic_result_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, start16 = 1'b0;
    logic rdy4 = 1'b1, rdy16 = 1'b0;
    logic [1:0]  rsel4, csel4;
    logic [3:0]  rsel16, csel16;
    logic [15:0] bso4, bso16;
    logic [15:0] mem16 [256];
    logic busy4, done4, busy16, done16;
    int cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_result_drain_if #(.size(4),  .nbits(16)) s4 ();
    systolic_result_drain_if #(.size(16), .nbits(16)) s16 ();
    assign s4.send_rdy  = rdy4;
    assign s16.send_rdy = rdy16;

    // datapath stubs: s[r][c] = 16*r + c for size 4, random table for size 16
    assign bso4  = {10'd0, rsel4, 2'b00, csel4};
    assign bso16 = mem16[{rsel16, csel16}];

    systolic_result_drain #(.size(4), .nbits(16)) u4 (
        .clk(clk), .rst(rst), .start(start4), .out_rsel(rsel4), .out_csel(csel4),
        .b_s_out(bso4), .send(s4), .busy(busy4), .done(done4));
    systolic_result_drain #(.size(16), .nbits(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .out_rsel(rsel16), .out_csel(csel16),
        .b_s_out(bso16), .send(s16), .busy(busy16), .done(done16));

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: a drain is the sequence of words n = 0..size*size-1,
    // with idx = n and value s[n/size][n%size]; consumed one per handshake.
    int          n     [2] = '{0, 0};
    int          words [2] = '{0, 0};
    int          dones [2] = '{0, 0};
    logic        pv    [2] = '{1'b0, 1'b0};
    logic        pr    [2] = '{1'b0, 1'b0};
    logic [15:0] pm    [2];
    logic [7:0]  pi    [2];
    logic [7:0]  psel  [2];

    task automatic step(input int k, input logic val, input logic rdy, input logic dn,
                        input logic [15:0] msg, input logic [7:0] idx, input logic [7:0] sel);
        int    total = (k == 0) ? 16 : 256;
        string p     = (k == 0) ? "u4 " : "u16 ";
        int    em;
        if (rst) begin
            n[k] = 0; pv[k] = 1'b0; pr[k] = 1'b0; psel[k] = sel;
            return;
        end
        if (pv[k] && !pr[k]) begin
            chk({p, "hold_val"}, int'(val), 1);
            chk({p, "hold_msg"}, int'(msg), int'(pm[k]));
            chk({p, "hold_idx"}, int'(idx), int'(pi[k]));
        end
        if (val && !pv[k]) chk({p, "fetch_sel"}, int'(psel[k]), n[k]);
        if (val && rdy) begin
            if (n[k] < total) begin
                em = (k == 0) ? 16 * (n[k] / 4) + n[k] % 4 : int'(mem16[n[k]]);
                chk({p, "word_msg"}, int'(msg), em);
                chk({p, "word_idx"}, int'(idx), n[k]);
            end else begin
                chk({p, "extra_word"}, n[k], total - 1);
            end
            n[k]++;
            words[k]++;
        end
        if (dn) begin
            chk({p, "done_after_last"}, n[k], total);
            n[k] = 0;
            dones[k]++;
        end
        pv[k] = val; pr[k] = rdy; pm[k] = msg; pi[k] = idx; psel[k] = sel;
    endtask

    always @(negedge clk) begin
        step(0, s4.send_val, rdy4, done4, s4.send_msg, {4'd0, s4.send_idx}, {4'd0, rsel4, csel4});
        step(1, s16.send_val, rdy16, done16, s16.send_msg, s16.send_idx, {rsel16, csel16});
    end

    task automatic wait_done4(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done4) begin
                at = cyc;
                break;
            end
        end
        chk("done4_seen", int'(at >= 0), 1);
    endtask

    task automatic pulse_start4(output int t0);
        @(posedge clk); #1 start4 = 1'b1; t0 = cyc;
        @(posedge clk); #1 start4 = 1'b0;
    endtask

    initial begin
        int t0, tv, td, ti, at, w0, d0, found;
        for (int i = 0; i < 256; i++) mem16[i] = 16'($urandom);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_val4",  int'(s4.send_val), 0);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        chk("rst_sel4",  int'({rsel4, csel4}), 0);
        chk("rst_msg4",  int'(s4.send_msg), 0);
        chk("rst_idx4",  int'(s4.send_idx), 0);
        chk("rst_val16", int'(s16.send_val), 0);
        chk("rst_busy16", int'(busy16), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // full drain, no backpressure: timing pinned against literal cycle offsets
        w0 = words[0]; d0 = dones[0];
        pulse_start4(t0);
        tv = -1; td = -1; ti = -1;
        for (int i = 0; i < 60 && ti < 0; i++) begin
            @(negedge clk);
            if (s4.send_val && tv < 0) tv = cyc - t0;
            if (done4) td = cyc - t0;
            if (td >= 0 && !busy4 && ti < 0) ti = cyc - t0;
        end
        chk("first_val_latency", tv, 2);
        chk("done_latency", td, 33);
        chk("idle_latency", ti, 34);
        @(posedge clk); #1;
        chk("drain_words", words[0] - w0, 16);
        chk("drain_dones", dones[0] - d0, 1);

        // backpressure on word (1,2)
        w0 = words[0]; d0 = dones[0];
        pulse_start4(t0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy4 && !s4.send_val && rsel4 == 2'd1 && csel4 == 2'd2) begin
                found = 1;
                break;
            end
        end
        chk("bp_fetch_found", found, 1);
        @(posedge clk); #1 rdy4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stall_val", int'(s4.send_val), 1);
            chk("bp_stall_msg", int'(s4.send_msg), 18);
            chk("bp_stall_idx", int'(s4.send_idx), 6);
        end
        @(posedge clk); #1 rdy4 = 1'b1;
        @(negedge clk);
        chk("bp_accept_msg", int'(s4.send_msg), 18);
        @(negedge clk);
        chk("bp_gap_val", int'(s4.send_val), 0);
        @(negedge clk);
        chk("bp_next_val", int'(s4.send_val), 1);
        chk("bp_next_msg", int'(s4.send_msg), 19);
        chk("bp_next_idx", int'(s4.send_idx), 7);
        wait_done4(60, at);
        @(posedge clk); #1;
        chk("bp_words", words[0] - w0, 16);
        chk("bp_dones", dones[0] - d0, 1);

        // start during SEND of (0,1) is ignored
        w0 = words[0]; d0 = dones[0];
        pulse_start4(t0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy4 && !s4.send_val && rsel4 == 2'd0 && csel4 == 2'd1) begin
                found = 1;
                break;
            end
        end
        chk("ign_fetch_found", found, 1);
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        wait_done4(60, at);
        repeat (10) @(posedge clk);
        #1;
        chk("ign_words", words[0] - w0, 16);
        chk("ign_dones", dones[0] - d0, 1);
        chk("ign_idle_busy", int'(busy4), 0);

        // reset during FETCH of (2,0)
        d0 = dones[0];
        pulse_start4(t0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s4.send_val && s4.send_idx == 4'd7) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid_found", found, 1);
        @(posedge clk); #1 rst = 1'b1;
        chk("rst_mid_in_fetch", int'({rsel4, csel4}), 8);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_val", int'(s4.send_val), 0);
        chk("rst_mid_busy", int'(busy4), 0);
        chk("rst_mid_sel", int'({rsel4, csel4}), 0);
        chk("rst_mid_done", int'(done4), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_done", dones[0] - d0, 0);
        w0 = words[0];
        pulse_start4(t0);
        wait_done4(60, at);
        @(posedge clk); #1;
        chk("rst_fresh_words", words[0] - w0, 16);
        chk("rst_fresh_dones", dones[0] - d0, 1);

        // back-to-back drains: restart in the cycle after done
        w0 = words[0]; d0 = dones[0];
        pulse_start4(t0);
        wait_done4(60, at);
        @(posedge clk); #1 start4 = 1'b1; t0 = cyc;
        @(posedge clk); #1 start4 = 1'b0;
        wait_done4(60, at);
        chk("b2b_done_latency", at - t0, 33);
        @(posedge clk); #1;
        chk("b2b_words", words[0] - w0, 32);
        chk("b2b_dones", dones[0] - d0, 2);

        // randomised backpressure on the size-16 instance
        w0 = words[1]; d0 = dones[1];
        @(posedge clk); #1 start16 = 1'b1; rdy16 = 1'($urandom_range(0, 1));
        @(posedge clk); #1 start16 = 1'b0;
        found = 0;
        for (int i = 0; i < 5000; i++) begin
            rdy16 = 1'($urandom_range(0, 1));
            if (done16) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rnd_done_seen", found, 1);
        rdy16 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rnd_words", words[1] - w0, 256);
        chk("rnd_dones", dones[1] - d0, 1);
        chk("rnd_idle_busy", int'(busy16), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
